// File: rtl/spi_mem_master.sv
// SPI master running single-byte read/write frames to the SPI memory slave.
// Latency: 1 + CS_SETUP + 33*HALF_PERIOD clk cycles from accept to rsp_valid.
// Backpressure: req_ready is high only in IDLE; requests wait until then.
module spi_mem_master #(
  parameter int HALF_PERIOD = 16,
  parameter int CS_SETUP    = 16,
  parameter int CS_GAP      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  // One shared phase counter, wide enough for the largest interval it times.
  localparam int MAX_A   = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAX_CNT = (MAX_A > CS_GAP) ? MAX_A : CS_GAP;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] SU_LAST  = CW'(CS_SETUP - 1);
  // The response cycle opens GAP; CS_GAP further cycles follow before IDLE.
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  // Frame bits 14..0; bit 15 goes straight onto mosi at accept.
  logic [14:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          rw_q, rw_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sclk_pin  = sclk_q;
  assign cs_pin    = cs_q;
  assign mosi_pin  = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // State register; reset aborts any frame and parks the pins idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state and pin sequencing for one 16-bit frame.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    mosi_d      = mosi_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (req_valid) begin
          // Frame: addr[6:0], rw, then data (zero for reads).
          tx_d    = {req_addr[5:0], req_rw, (req_rw ? 8'h00 : req_wdata)};
          mosi_d  = req_addr[6];
          rw_d    = req_rw;
          cs_d    = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == SU_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SHIFT: begin
        if (cnt_q == HP_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of the high phase: capture read data, then fall and
            // present the next bit while sclk is low.
            sclk_d = 1'b0;
            if (rw_q && (bit_q >= 5'd8)) begin
              rx_d = {rx_q[6:0], miso_pin};
            end
            mosi_d = tx_q[14];
            tx_d   = {tx_q[13:0], 1'b0};
            bit_d  = bit_q + 5'd1;
            if (bit_q == 5'd15) begin
              state_d = HOLD;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HOLD: begin
        if (cnt_q == HP_LAST) begin
          cnt_d       = '0;
          cs_d        = 1'b1;
          rsp_valid_d = 1'b1;
          if (rw_q) begin
            rsp_rdata_d = rx_q;
          end
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: two instances (default timing and the fast 8/8/8
// variant), each with a behavioural SPI memory slave on its pins. Expected
// responses are queued when a request is driven and checked on rsp_valid.
module tb_spi_mem_master;

  localparam int HP0 = 16, SU0 = 16, GP0 = 32;
  localparam int HP1 = 8,  SU1 = 8,  GP1 = 8;
  localparam int LAT0 = 1 + SU0 + 32 * HP0 + HP0;
  localparam int LAT1 = 1 + SU1 + 32 * HP1 + HP1;

  typedef struct {
    int          inst;
    int          lat;
    logic [15:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = 7'h00;
  logic [7:0] req_wdata = 8'h00;

  wire [1:0]      req_ready, rsp_valid, busy, sclk, cs, mosi;
  wire [1:0][7:0] rsp_rdata;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  logic [7:0] ref_mem [2][128];
  logic [7:0] last_rd [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int HP = (g == 0) ? HP0 : HP1;
    localparam int SU = (g == 0) ? SU0 : SU1;
    localparam int GP = (g == 0) ? GP0 : GP1;

    logic        miso_g;
    logic [7:0]  mem [128];
    logic [15:0] shreg;
    int          rises, falls;
    logic        mosi_rise;
    logic        rd_en;
    logic [7:0]  rd_byte;
    int          acc_cyc;

    spi_mem_master #(
      .HALF_PERIOD(HP),
      .CS_SETUP   (SU),
      .CS_GAP     (GP)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_rw   (req_rw),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .busy     (busy[g]),
      .sclk_pin (sclk[g]),
      .cs_pin   (cs[g]),
      .mosi_pin (mosi[g]),
      .miso_pin (miso_g)
    );

    // Behavioural SPI memory: mode-0 capture on rise, read data shifted out
    // after falls 8..15, write committed only for a complete 16-bit frame.
    initial begin
      logic s_p, c_p;
      for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h29;
      s_p = 1'b0; c_p = 1'b1;
      miso_g = 1'b1; shreg = '0; rises = 0; falls = 0;
      mosi_rise = 1'b0; rd_en = 1'b0; rd_byte = 8'h00;
      forever begin
        @(sclk[g] or cs[g]);
        if (c_p && !cs[g]) begin
          rises = 0; falls = 0; shreg = '0; rd_en = 1'b0; miso_g = 1'b1;
        end
        if (!c_p && cs[g]) begin
          if (rises == 16 && !shreg[8]) mem[shreg[15:9]] = shreg[7:0];
          miso_g = 1'b1;
        end
        if (s_p != sclk[g]) begin
          chk("sclk_edge_while_cs_low", 32'(cs[g]), 32'd0);
          if (sclk[g]) begin
            shreg = {shreg[14:0], mosi[g]};
            mosi_rise = mosi[g];
            rises++;
          end else begin
            falls++;
            if (falls == 8) begin
              rd_en   = shreg[0];
              rd_byte = mem[shreg[7:1]];
            end
            if (rd_en && falls >= 8 && falls <= 15) miso_g = rd_byte[15 - falls];
            else miso_g = 1'b1;
          end
        end
        s_p = sclk[g]; c_p = cs[g];
      end
    end

    // Response checker and mosi stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
      exp_t e;
      if (!reset && req_valid[g] && req_ready[g]) acc_cyc = cyc;
      if (!cs[g] && sclk[g]) chk("mosi_stable_while_sclk_high", 32'(mosi[g]), 32'(mosi_rise));
      if (rsp_valid[g]) begin
        chk("rsp_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rsp_instance", g, e.inst);
          chk("latency", cyc - acc_cyc, e.lat);
          chk("mosi_frame", 32'(shreg), 32'(e.frame));
          chk("sclk_rises", rises, 32'd16);
          chk("rsp_rdata", 32'(rsp_rdata[g]), 32'(e.rdata));
        end
      end
    end
  end

  // Drive one request at a negedge, wait for acceptance, queue its expectation.
  task automatic issue(input int g, input logic rw, input logic [6:0] a, input logic [7:0] d,
                       input bit keep, input bit expect_rsp, output int acc);
    exp_t e;
    int   n;
    req_rw = rw; req_addr = a; req_wdata = d; req_valid[g] = 1'b1;
    n = 0;
    while (!req_ready[g] && n < 3000) begin @(negedge clk); n++; end
    chk("accept_in_time", 32'(n < 3000), 32'd1);
    acc = cyc;
    if (expect_rsp) begin
      e.inst  = g;
      e.lat   = (g == 0) ? LAT0 : LAT1;
      e.frame = {a, rw, (rw ? 8'h00 : d)};
      if (rw) last_rd[g] = ref_mem[g][a];
      else    ref_mem[g][a] = d;
      e.rdata = last_rd[g];
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    if (!keep) begin
      req_valid[g] = 1'b0;
      req_rw = 1'($urandom); req_addr = 7'($urandom); req_wdata = 8'($urandom);
    end
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy[g]) && n < 5000) begin @(negedge clk); n++; end
    chk("done_in_time", 32'(n < 5000), 32'd1);
  endtask

  initial begin
    int a1, a2, r, cs_hi, n, falls_seen, rsp_seen;
    logic prev;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 128; i++) ref_mem[g][i] = 8'(i) ^ 8'h29;
      last_rd[g] = 8'h00;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_cs_pin", 32'(cs[g]), 32'd1);
      chk("rst_sclk_pin", 32'(sclk[g]), 32'd0);
      chk("rst_mosi_pin", 32'(mosi[g]), 32'd0);
      chk("rst_req_ready", 32'(req_ready[g]), 32'd1);
      chk("rst_busy", 32'(busy[g]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[g]), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata[g]), 32'h00);
    end
    reset = 1'b0;
    @(negedge clk);

    // Read 0x15 (slave holds 0x3C), write 0xA5 there, read it back.
    issue(0, 1'b1, 7'h15, 8'h00, 1'b0, 1'b1, a1); wait_done(0);
    issue(0, 1'b0, 7'h15, 8'hA5, 1'b0, 1'b1, a1); wait_done(0);
    issue(0, 1'b1, 7'h15, 8'h00, 1'b0, 1'b1, a1); wait_done(0);

    // Abort a write with reset once bit 5 has been shifted out.
    issue(0, 1'b0, 7'h40, 8'h77, 1'b0, 1'b0, a1);
    n = 0; falls_seen = 0; prev = sclk[0];
    while (falls_seen < 6 && n < 2000) begin
      @(negedge clk);
      if (prev && !sclk[0]) falls_seen++;
      prev = sclk[0];
      n++;
    end
    chk("abort_reached_bit5", falls_seen, 32'd6);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_cs_pin", 32'(cs[0]), 32'd1);
    chk("abort_sclk_pin", 32'(sclk[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
    chk("abort_rsp_rdata", 32'(rsp_rdata[0]), 32'h00);
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    rsp_seen = 0;
    repeat (700) begin @(negedge clk); if (rsp_valid[0]) rsp_seen++; end
    chk("no_rsp_after_abort", rsp_seen, 32'd0);

    // Back-to-back with req_valid held: write 0xC3 to 0x7F, then read it.
    issue(0, 1'b0, 7'h7F, 8'hC3, 1'b1, 1'b1, a1);
    req_rw = 1'b1; req_addr = 7'h7F; req_wdata = 8'h00;
    n = 0;
    while (!rsp_valid[0] && n < 2000) begin @(negedge clk); n++; end
    r = cyc; cs_hi = 0;
    while (!req_ready[0] && n < 4000) begin
      if (cs[0]) cs_hi++;
      @(negedge clk);
      n++;
    end
    issue(0, 1'b1, 7'h7F, 8'h00, 1'b0, 1'b1, a2);
    chk("b2b_accept_gap", a2 - r, GP0 + 1);
    chk("b2b_cs_high_min", 32'(cs_hi >= GP0), 32'd1);
    wait_done(0);

    // All-zero write then read at address 0 (initial content is 0x29).
    issue(0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, a1); wait_done(0);
    issue(0, 1'b1, 7'h00, 8'h00, 1'b0, 1'b1, a1); wait_done(0);

    // Fast-timing instance: same frames, shorter latency.
    issue(1, 1'b0, 7'h15, 8'hA5, 1'b0, 1'b1, a1); wait_done(1);
    issue(1, 1'b1, 7'h2A, 8'h00, 1'b0, 1'b1, a1); wait_done(1);
    issue(1, 1'b1, 7'h15, 8'h00, 1'b0, 1'b1, a1); wait_done(1);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_mem_master.md
Name: spi_mem_master

Overview:
- SPI master that sequences single-byte read/write transactions to the on-board SPI memory slave from a parallel request interface.
- Sits between system logic, clocked on `clk`, and the slave's `sclk_pin`/`cs_pin`/`mosi_pin`/`miso_pin`.
- Generates a slow SPI clock so the slave's input conditioners can synchronise and debounce every edge.
- Returns read data on a one-cycle response strobe.

Parameters:
- HALF_PERIOD, 16: `clk` cycles per SPI clock half-period; legal range 8..255.
- CS_SETUP, 16: `clk` cycles from cs falling to the first sclk rising edge.
- CS_GAP, 32: minimum `clk` cycles cs stays high between transactions.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request (high only in IDLE).
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  7  memory address.
- req_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse when a transaction completes.
- rsp_rdata  out  8  read data; holds its value until the next read completes.
- busy  out  1  high whenever not in IDLE.
- sclk_pin  out  1  SPI clock; idles low.
- cs_pin  out  1  chip select, active low; idles high.
- mosi_pin  out  1  master out.
- miso_pin  in  1  slave out; tri-stated by the slave outside read data.

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE
  - `sclk_pin`=0, `cs_pin`=1, `mosi_pin`=0
  - `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=8'h00
  - all counters cleared
- Reset mid-transaction aborts it; cs returns high at once and no `rsp_valid` is issued.
- Handshake: a request is accepted on a cycle where `req_valid` && `req_ready`.
  - `req_addr`, `req_rw` and `req_wdata` are latched in that cycle.
  - Inputs are don't-care afterwards.
- Frame format: 16 bits, MSB first.
  - Bits 15..9 = addr[6:0]; bit 8 = rw; bits 7..0 = wdata for a write, or 0 for a read.
- States:
  - IDLE: `cs_pin`=1, `sclk_pin`=0.
    - On accept: load the 16-bit TX shifter, drive `mosi_pin` = bit 15, drop `cs_pin`, go to SETUP.
  - SETUP: count CS_SETUP cycles, then go to SHIFT with the bit counter = 0.
  - SHIFT: per bit, hold sclk low for HALF_PERIOD cycles, then high for HALF_PERIOD cycles.
    - On the last `clk` cycle of the high phase, for read frames only, with bit counter ≥ 8: shift `miso_pin` into the RX register LSB-first-in, so the MSB ends in rx[7].
    - On the falling edge: advance the bit counter and present the next TX bit on `mosi_pin` in the same cycle.
    - After the 16th falling edge, go to HOLD.
  - HOLD: hold sclk low for HALF_PERIOD cycles, then raise `cs_pin`.
    - Pulse `rsp_valid` for one cycle; for reads, load `rsp_rdata` from RX in the same cycle.
    - Go to GAP.
  - GAP: count CS_GAP cycles with `cs_pin`=1, then go to IDLE.
- Timing: total latency from accept to `rsp_valid` = 1 + CS_SETUP + 32·HALF_PERIOD + HALF_PERIOD `clk` cycles. With defaults this is 545.
- `mosi_pin` changes only while sclk is low. No sclk edge occurs while `cs_pin`=1.
- `rsp_valid` is never asserted for the same transaction twice. Write completion also pulses `rsp_valid`, with `rsp_rdata` unchanged.
- Back-to-back: `req_ready` returns high only after GAP, so successive cs-low windows are separated by ≥ CS_GAP cycles.
- `req_valid` outside IDLE is ignored; it is neither queued nor dropped silently — the requester holds it until `req_ready`.
- Counters are sized to hold max(HALF_PERIOD, CS_SETUP, CS_GAP); the bit counter is 5 bits.

Test Plan:
- Reset asserted mid-SHIFT (after bit 5) → within the same cycle `cs_pin`=1, `sclk_pin`=0, `busy`=0; no `rsp_valid` follows; the next request completes normally.
- Write addr 7'h15, data 8'hA5 → mosi sampled on 16 sclk rising edges reads 0x2AA5; exactly 16 rising edges while cs low; `rsp_valid` pulses once at cycle 545 after accept.
- Read addr 7'h15, slave model drives 8'h3C on miso at falling edges of bits 8..15 → `rsp_rdata`=8'h3C with `rsp_valid`; mosi frame = 0x2B00.
- Full-system run against spimemory: write 8'hC3 to 7'h7F, then read 7'h7F → read returns 8'hC3; write 8'h00 to 7'h00, then read → 8'h00.
- `req_valid` held high continuously with two queued requests → second accept occurs exactly CS_GAP+1 cycles after the first `rsp_valid`; cs is high for ≥32 cycles between frames.
- HALF_PERIOD=8, CS_SETUP=8, CS_GAP=8 → latency 1+8+256+8 = 273 cycles; frame contents are identical to the default case.
